bw_frame_packer: RTL and testbench
==================================

Name: bw_frame_packer

Overview:
- Receives the per-pixel 1-bit black/white stream from the grayscale/threshold stage and packs it into 16-bit words for the SDRAM write port.
- Counts pixels and words per frame, and flushes a zero-padded partial word at end of frame.
- Exerts backpressure on the pixel source while the SDRAM write FIFO is full.
- Sits between the grayscale stage and the SDRAM controller write side; it is the write-side counterpart of the frame read path.

Parameters:
- WORD_W, 16, packed word width; pixel k of a word occupies bit k (LSB = earliest pixel).
- FRAME_W, 640, pixels per line.
- FRAME_H, 480, lines per frame; frame length N = FRAME_W*FRAME_H.

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  arms capture of one frame; sampled only in IDLE.
- i_valid  in  1  pixel valid from the upstream stage.
- i_bw  in  1  pixel value (1 = black).
- o_ready  out  1  pixel accepted on a cycle where i_valid && o_ready.
- o_wr_req  out  1  write strobe to the SDRAM write FIFO.
- o_wr_data  out  WORD_W  packed word.
- o_word_idx  out  15  index of the current word within the frame (0-based).
- i_wr_full  in  1  SDRAM write FIFO full.
- o_busy  out  1  high in any state other than IDLE.
- o_frame_done  out  1  one-cycle pulse after the last word is written.
- o_black_cnt  out  19  number of i_bw==1 pixels accepted in the current or last frame.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE.
  - o_ready=0, o_wr_req=0, o_wr_data=0, o_word_idx=0, o_busy=0, o_frame_done=0, o_black_cnt=0.
  - Internal bit_cnt=0, pix_cnt=0.
  - Reset mid-frame abandons the frame with no flush.
- States: IDLE, PACK, WRITE, DONE.
- IDLE:
  - o_ready=0.
  - i_start=1 -> PACK next cycle; clears pix_cnt, bit_cnt, o_word_idx, o_black_cnt and the shift register.
- PACK:
  - o_ready=1.
  - On accept: shift_reg[bit_cnt] <= i_bw; bit_cnt++; pix_cnt++; o_black_cnt += i_bw.
  - Idle cycles (i_valid=0) hold all state.
  - If the accepted pixel fills bit WORD_W-1, or is pixel N-1 (last of frame), latch the word into o_wr_data, with unfilled upper bits = 0, and go to WRITE.
- WRITE:
  - o_ready=0.
  - o_wr_req = (state==WRITE) && !i_wr_full, combinational. A word is written on any cycle where o_wr_req=1.
  - o_wr_data and o_word_idx are held stable from entry until the write.
  - After the write: clear bit_cnt and the shift register.
    - If pix_cnt==N -> DONE.
    - Otherwise o_word_idx++ and return to PACK.
- Latency: last pixel of a word accepted in cycle T -> o_wr_req=1 in cycle T+1 when i_wr_full=0; PACK resumes (o_ready=1) in cycle T+2.
- DONE: o_frame_done=1 for exactly one cycle, then IDLE.
  - o_black_cnt and o_word_idx (= last word index) hold until the next i_start.
- i_start in PACK/WRITE/DONE is ignored; there is no restart mid-frame.
- i_wr_full held indefinitely: stays in WRITE, no pixels accepted, no data loss.
- Word count per frame = ceil(N/WORD_W); 640x480 gives 19200 words (indices 0..19199).
- o_black_cnt saturates at 2^19-1; unreachable at defaults.

Test Plan:
- FRAME_W=8, FRAME_H=4, pixels alternate 0,1,0,1… with continuous i_valid, i_wr_full=0 -> two writes of 0xAAAA at o_word_idx 0 then 1; o_frame_done pulses one cycle after the second write; o_black_cnt=16.
- FRAME_W=5, FRAME_H=4, all i_bw=1 -> writes 0xFFFF (idx 0) then 0x000F (idx 1); o_black_cnt=20; o_busy=0 after the done pulse.
- Same as the first case with i_wr_full=1 for 5 cycles when the first word completes -> o_wr_req=0 and o_ready=0 for those cycles; o_wr_data=0xAAAA stable; write occurs on the cycle i_wr_full falls; no pixel lost.
- Random i_valid gaps (~50% duty), default sizes, all pixels 0 -> exactly 19200 writes of 0x0000; final o_word_idx=19199; o_black_cnt=0.
- i_start pulsed during PACK -> no counter clear, frame completes normally. Then i_rst_n=0 for one cycle mid-frame in a new frame -> all outputs return to reset values immediately, and no o_frame_done pulse.

Source files
------------

// File: rtl/bw_frame_packer.sv
// Packs a 1-bit black/white pixel stream into WORD_W-bit words for the SDRAM
// write FIFO, padding the final partial word of a frame with zeros.
module bw_frame_packer #(
    parameter int WORD_W  = 16,
    parameter int FRAME_W = 640,
    parameter int FRAME_H = 480
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_valid,
    input  logic              i_bw,
    output logic              o_ready,
    output logic              o_wr_req,
    output logic [WORD_W-1:0] o_wr_data,
    output logic [14:0]       o_word_idx,
    input  logic              i_wr_full,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic [18:0]       o_black_cnt
);

    localparam int              N        = FRAME_W * FRAME_H;
    localparam int              BIT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
    localparam logic [18:0]      LAST_PIX = 19'(N - 1);
    localparam logic [18:0]      FULL_PIX = 19'(N);
    localparam logic [18:0]      BLK_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        PACK,
        WRITE,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [18:0]       pix_cnt_q, pix_cnt_d;
    logic [14:0]       word_idx_q, word_idx_d;
    logic [18:0]       black_cnt_q, black_cnt_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            wr_data_q   <= '0;
            bit_cnt_q   <= '0;
            pix_cnt_q   <= '0;
            word_idx_q  <= '0;
            black_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            wr_data_q   <= wr_data_d;
            bit_cnt_q   <= bit_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            word_idx_q  <= word_idx_d;
            black_cnt_q <= black_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        wr_data_d   = wr_data_q;
        bit_cnt_d   = bit_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        word_idx_d  = word_idx_q;
        black_cnt_d = black_cnt_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d     = PACK;
                    shift_d     = '0;
                    bit_cnt_d   = '0;
                    pix_cnt_d   = '0;
                    word_idx_d  = '0;
                    black_cnt_d = '0;
                end
            end
            PACK: begin
                if (i_valid) begin
                    shift_d[bit_cnt_q] = i_bw;
                    bit_cnt_d          = bit_cnt_q + 1'b1;
                    pix_cnt_d          = pix_cnt_q + 19'd1;
                    if (i_bw && (black_cnt_q != BLK_MAX)) begin
                        black_cnt_d = black_cnt_q + 19'd1;
                    end
                    // Upper bits are still zero from the clear, which pads a short last word.
                    if ((bit_cnt_q == LAST_BIT) || (pix_cnt_q == LAST_PIX)) begin
                        wr_data_d = shift_d;
                        state_d   = WRITE;
                    end
                end
            end
            WRITE: begin
                if (!i_wr_full) begin
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    if (pix_cnt_q == FULL_PIX) begin
                        state_d = DONE;
                    end else begin
                        word_idx_d = word_idx_q + 15'd1;
                        state_d    = PACK;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_ready      = (state_q == PACK);
    assign o_wr_req     = (state_q == WRITE) && !i_wr_full;
    assign o_wr_data    = wr_data_q;
    assign o_word_idx   = word_idx_q;
    assign o_busy       = (state_q != IDLE);
    assign o_frame_done = (state_q == DONE);
    assign o_black_cnt  = black_cnt_q;

endmodule

// File: tb/tb_bw_frame_packer.sv
// Bench for bw_frame_packer: three instances with different frame sizes share
// the pixel inputs; a scoreboard queue holds expected words from a pixel model.
module tb_bw_frame_packer;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [2:0]  start_v;
    logic        i_valid;
    logic        i_bw;
    logic        i_wr_full;

    logic [2:0]  ready_v, wr_req_v, busy_v, done_v;
    logic [15:0] data_v  [3];
    logic [14:0] idx_v   [3];
    logic [18:0] black_v [3];

    logic [1:0]  sel;
    logic        obs_ready, obs_wr_req, obs_busy, obs_done;
    logic [15:0] obs_data;
    logic [14:0] obs_idx;
    logic [18:0] obs_black;

    typedef struct packed {
        logic [14:0] idx;
        logic [15:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    int          last_wr_cyc = -10;

    logic [15:0] m_word;
    int          m_bit;
    int          m_idx;
    int          m_black;
    logic [15:0] last_word;

    always #5 i_clk = ~i_clk;

    bw_frame_packer #(.WORD_W(16), .FRAME_W(8), .FRAME_H(4)) dut_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(start_v[0]), .i_valid(i_valid),
        .i_bw(i_bw), .o_ready(ready_v[0]), .o_wr_req(wr_req_v[0]), .o_wr_data(data_v[0]),
        .o_word_idx(idx_v[0]), .i_wr_full(i_wr_full), .o_busy(busy_v[0]),
        .o_frame_done(done_v[0]), .o_black_cnt(black_v[0]));

    bw_frame_packer #(.WORD_W(16), .FRAME_W(5), .FRAME_H(4)) dut_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(start_v[1]), .i_valid(i_valid),
        .i_bw(i_bw), .o_ready(ready_v[1]), .o_wr_req(wr_req_v[1]), .o_wr_data(data_v[1]),
        .o_word_idx(idx_v[1]), .i_wr_full(i_wr_full), .o_busy(busy_v[1]),
        .o_frame_done(done_v[1]), .o_black_cnt(black_v[1]));

    // Scaled-down "large" frame (40x30) keeps the random-gap run short.
    bw_frame_packer #(.WORD_W(16), .FRAME_W(40), .FRAME_H(30)) dut_c (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(start_v[2]), .i_valid(i_valid),
        .i_bw(i_bw), .o_ready(ready_v[2]), .o_wr_req(wr_req_v[2]), .o_wr_data(data_v[2]),
        .o_word_idx(idx_v[2]), .i_wr_full(i_wr_full), .o_busy(busy_v[2]),
        .o_frame_done(done_v[2]), .o_black_cnt(black_v[2]));

    always_comb begin
        obs_ready  = ready_v[sel];
        obs_wr_req = wr_req_v[sel];
        obs_busy   = busy_v[sel];
        obs_done   = done_v[sel];
        obs_data   = data_v[sel];
        obs_idx    = idx_v[sel];
        obs_black  = black_v[sel];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        chk_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Write monitor: pops the scoreboard on every write, checks the done pulse timing.
    always @(negedge i_clk) begin
        cyc++;
        if (obs_wr_req) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            if (sb_q.size() == 0) begin
                checkOutput("wr_unexpected", 32'(obs_data), 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("wr_data", 32'(obs_data), 32'(e.data));
                checkOutput("wr_idx", 32'(obs_idx), 32'(e.idx));
            end
        end
        if (obs_done) begin
            done_cnt++;
            checkOutput("done_after_last_wr", 32'(cyc - last_wr_cyc), 32'd1);
            checkOutput("sb_empty_at_done", 32'(sb_q.size()), 32'd0);
        end
    end

    // pattern: 0 = alternating 0,1; 1 = all ones; 2 = all zeros.
    task automatic applyStimulus(input int frame_n, input int feed_n, input int pattern,
                                 input bit rand_gaps, input int stall_word, input int stall_len,
                                 input int start_at);
        int pix;
        int stall_left;
        int guard;
        pix = 0; stall_left = 0; guard = 0;
        m_word = '0; m_bit = 0; m_idx = 0; m_black = 0;
        wr_cnt = 0;
        start_v = '0;
        start_v[sel] = 1'b1;
        @(posedge i_clk); #1;
        start_v = '0;
        @(negedge i_clk);
        checkOutput("busy_after_start", 32'(obs_busy), 32'd1);
        @(posedge i_clk); #1;
        while (pix < feed_n && guard < 20000) begin
            guard++;
            if (stall_left > 0) begin
                i_wr_full = 1'b1;
                i_valid   = 1'b0;
                @(negedge i_clk);
                checkOutput("stall_wr_req", 32'(obs_wr_req), 32'd0);
                checkOutput("stall_ready", 32'(obs_ready), 32'd0);
                checkOutput("stall_data", 32'(obs_data), 32'(last_word));
                stall_left--;
            end else begin
                i_wr_full = 1'b0;
                i_valid   = rand_gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                i_bw      = (pattern == 0) ? 1'(pix % 2) : (pattern == 1) ? 1'b1 : 1'b0;
                start_v   = '0;
                if (pix == start_at) start_v[sel] = 1'b1;
                if (i_valid && obs_ready) begin
                    m_word[m_bit] = i_bw;
                    m_black += int'(i_bw);
                    pix++;
                    if (m_bit == 15 || pix == frame_n) begin
                        sb_q.push_back('{idx: 15'(m_idx), data: m_word});
                        last_word = m_word;
                        if (m_idx == stall_word) stall_left = stall_len;
                        m_idx++;
                        m_word = '0;
                        m_bit = 0;
                    end else begin
                        m_bit++;
                    end
                end
            end
            @(posedge i_clk); #1;
        end
        if (guard >= 20000) checkOutput("feed_timeout", 32'd0, 32'd1);
        i_valid   = 1'b0;
        i_wr_full = 1'b0;
        start_v   = '0;
    endtask

    task automatic waitDone();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge i_clk);
            if (obs_done) seen = 1'b1;
        end
        checkOutput("done_seen", 32'(seen), 32'd1);
        @(negedge i_clk);
        checkOutput("done_one_cycle", 32'(obs_done), 32'd0);
        checkOutput("busy_after_done", 32'(obs_busy), 32'd0);
    endtask

    initial begin
        int snap;
        sel = 2'd0; start_v = '0; i_valid = 1'b0; i_bw = 1'b0; i_wr_full = 1'b0;
        i_rst_n = 1'b0;
        #12;
        for (int d = 0; d < 3; d++) begin
            sel = 2'(d);
            #1;
            checkOutput("rst_ready", 32'(obs_ready), 32'd0);
            checkOutput("rst_busy", 32'(obs_busy), 32'd0);
            checkOutput("rst_wr_req", 32'(obs_wr_req), 32'd0);
            checkOutput("rst_data", 32'(obs_data), 32'd0);
            checkOutput("rst_black", 32'(obs_black), 32'd0);
        end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        $display("[TB] 8x4 alternating pixels");
        sel = 2'd0;
        applyStimulus(32, 32, 0, 1'b0, -1, 0, -1);
        waitDone();
        checkOutput("a_wr_cnt", 32'(wr_cnt), 32'd2);
        checkOutput("a_black", 32'(obs_black), 32'd16);
        checkOutput("a_last_idx", 32'(obs_idx), 32'd1);
        checkOutput("a_last_data", 32'(obs_data), 32'hAAAA);

        $display("[TB] 5x4 all ones, zero-padded tail");
        sel = 2'd1;
        applyStimulus(20, 20, 1, 1'b0, -1, 0, -1);
        waitDone();
        checkOutput("b_wr_cnt", 32'(wr_cnt), 32'd2);
        checkOutput("b_black", 32'(obs_black), 32'd20);
        checkOutput("b_last_data", 32'(obs_data), 32'h000F);

        $display("[TB] 8x4 with write FIFO full after first word");
        sel = 2'd0;
        applyStimulus(32, 32, 0, 1'b0, 0, 5, -1);
        waitDone();
        checkOutput("s_wr_cnt", 32'(wr_cnt), 32'd2);
        checkOutput("s_black", 32'(obs_black), 32'd16);

        $display("[TB] 40x30 zeros with random valid gaps");
        sel = 2'd2;
        applyStimulus(1200, 1200, 2, 1'b1, -1, 0, -1);
        waitDone();
        checkOutput("c_wr_cnt", 32'(wr_cnt), 32'd75);
        checkOutput("c_last_idx", 32'(obs_idx), 32'd74);
        checkOutput("c_black", 32'(obs_black), 32'd0);

        $display("[TB] 8x4 with start pulsed mid-frame");
        sel = 2'd0;
        applyStimulus(32, 32, 0, 1'b0, -1, 0, 7);
        waitDone();
        checkOutput("p_wr_cnt", 32'(wr_cnt), 32'd2);
        checkOutput("p_black", 32'(obs_black), 32'd16);
        checkOutput("p_last_idx", 32'(obs_idx), 32'd1);

        $display("[TB] 8x4 reset mid-frame");
        applyStimulus(32, 20, 0, 1'b0, -1, 0, -1);
        checkOutput("r_busy_pre", 32'(obs_busy), 32'd1);
        checkOutput("r_black_pre", 32'(obs_black), 32'd10);
        snap = done_cnt;
        i_rst_n = 1'b0;
        #1;
        checkOutput("r_ready", 32'(obs_ready), 32'd0);
        checkOutput("r_busy", 32'(obs_busy), 32'd0);
        checkOutput("r_wr_req", 32'(obs_wr_req), 32'd0);
        checkOutput("r_data", 32'(obs_data), 32'd0);
        checkOutput("r_idx", 32'(obs_idx), 32'd0);
        checkOutput("r_black", 32'(obs_black), 32'd0);
        checkOutput("r_done", 32'(obs_done), 32'd0);
        sb_q.delete();
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        repeat (10) @(negedge i_clk);
        checkOutput("r_no_done", 32'(done_cnt - snap), 32'd0);
        checkOutput("r_idle", 32'(obs_busy), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
